sha_round_ctrl: RTL



---
 rtl/sha_round_ctrl_pkg.sv | 85 ++++++++
 rtl/sha_round_ctrl_if.sv | 16 +
 rtl/sha_round_ctrl_adder.sv | 60 ++++++
 rtl/sha_round_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/sha_round_ctrl_pkg.sv
// SHA-256 shared definitions: round constants, IV, state encoding, round functions.
// Latency: n/a (constants and pure combinational helpers).
// Backpressure: n/a.
`ifndef IDX32
`define IDX32(n) ((n)*32+31):((n)*32)
`endif

package sha_round_ctrl_pkg;

   typedef logic [31:0]  word_t;
   typedef logic [255:0] hash_t;
   typedef logic [511:0] block_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_FINAL = 2'd2
   } state_t;

   // Carry-save pair: sum and carry vectors whose total is the operand sum.
   typedef struct packed {
      word_t s;
      word_t c;
   } csa_t;

   localparam int ROUNDS = 64;

   localparam word_t IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic word_t rotr(input word_t x, input int unsigned n);
      rotr = (x >> n) | (x << (32 - n));
   endfunction

   function automatic word_t f_ch(input word_t e, input word_t f, input word_t g);
      f_ch = (e & f) ^ (~e & g);
   endfunction

   function automatic word_t f_maj(input word_t a, input word_t b, input word_t c);
      f_maj = (a & b) ^ (a & c) ^ (b & c);
   endfunction

   function automatic word_t f_bsig0(input word_t x);
      f_bsig0 = rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic word_t f_bsig1(input word_t x);
      f_bsig1 = rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic word_t f_ssig0(input word_t x);
      f_ssig0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t f_ssig1(input word_t x);
      f_ssig1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Round constant lookup; the last entry doubles as the default so the
   // case is trivially full.
   function automatic word_t k_of(input logic [5:0] t);
      case (t)
         6'd0:  k_of = 32'h428a2f98;  6'd1:  k_of = 32'h71374491;  6'd2:  k_of = 32'hb5c0fbcf;  6'd3:  k_of = 32'he9b5dba5;
         6'd4:  k_of = 32'h3956c25b;  6'd5:  k_of = 32'h59f111f1;  6'd6:  k_of = 32'h923f82a4;  6'd7:  k_of = 32'hab1c5ed5;
         6'd8:  k_of = 32'hd807aa98;  6'd9:  k_of = 32'h12835b01;  6'd10: k_of = 32'h243185be;  6'd11: k_of = 32'h550c7dc3;
         6'd12: k_of = 32'h72be5d74;  6'd13: k_of = 32'h80deb1fe;  6'd14: k_of = 32'h9bdc06a7;  6'd15: k_of = 32'hc19bf174;
         6'd16: k_of = 32'he49b69c1;  6'd17: k_of = 32'hefbe4786;  6'd18: k_of = 32'h0fc19dc6;  6'd19: k_of = 32'h240ca1cc;
         6'd20: k_of = 32'h2de92c6f;  6'd21: k_of = 32'h4a7484aa;  6'd22: k_of = 32'h5cb0a9dc;  6'd23: k_of = 32'h76f988da;
         6'd24: k_of = 32'h983e5152;  6'd25: k_of = 32'ha831c66d;  6'd26: k_of = 32'hb00327c8;  6'd27: k_of = 32'hbf597fc7;
         6'd28: k_of = 32'hc6e00bf3;  6'd29: k_of = 32'hd5a79147;  6'd30: k_of = 32'h06ca6351;  6'd31: k_of = 32'h14292967;
         6'd32: k_of = 32'h27b70a85;  6'd33: k_of = 32'h2e1b2138;  6'd34: k_of = 32'h4d2c6dfc;  6'd35: k_of = 32'h53380d13;
         6'd36: k_of = 32'h650a7354;  6'd37: k_of = 32'h766a0abb;  6'd38: k_of = 32'h81c2c92e;  6'd39: k_of = 32'h92722c85;
         6'd40: k_of = 32'ha2bfe8a1;  6'd41: k_of = 32'ha81a664b;  6'd42: k_of = 32'hc24b8b70;  6'd43: k_of = 32'hc76c51a3;
         6'd44: k_of = 32'hd192e819;  6'd45: k_of = 32'hd6990624;  6'd46: k_of = 32'hf40e3585;  6'd47: k_of = 32'h106aa070;
         6'd48: k_of = 32'h19a4c116;  6'd49: k_of = 32'h1e376c08;  6'd50: k_of = 32'h2748774c;  6'd51: k_of = 32'h34b0bcb5;
         6'd52: k_of = 32'h391c0cb3;  6'd53: k_of = 32'h4ed8aa4a;  6'd54: k_of = 32'h5b9cca4f;  6'd55: k_of = 32'h682e6ff3;
         6'd56: k_of = 32'h748f82ee;  6'd57: k_of = 32'h78a5636f;  6'd58: k_of = 32'h84c87814;  6'd59: k_of = 32'h8cc70208;
         6'd60: k_of = 32'h90befffa;  6'd61: k_of = 32'ha4506ceb;  6'd62: k_of = 32'hbef9a3f7;
         default: k_of = 32'hc67178f2;
      endcase
   endfunction

endpackage

// File: rtl/sha_round_ctrl_if.sv
// Block-feed / digest handshake bundle between the padding logic and the round controller.
// Latency: n/a (wires only).
// Backpressure: none; i_start is dropped by the slave while it reports busy.
interface sha_round_ctrl_if;
   import sha_round_ctrl_pkg::*;

   logic   i_start;   // start request, honoured only when idle
   logic   i_first;   // 1: start from IV, 0: chain from current hash
   block_t i_block;   // W0 in [511:480] .. W15 in [31:0]
   logic   o_busy;    // compression in flight
   logic   o_done;    // one-cycle pulse, o_hash valid from here
   hash_t  o_hash;    // H0 in [255:224] .. H7 in [31:0]

   modport master (output i_start, i_first, i_block, input o_busy, o_done, o_hash);
   modport slave  (input i_start, i_first, i_block, output o_busy, o_done, o_hash);
endinterface

// File: rtl/sha_round_ctrl_adder.sv
// SHA-256 round adder: T1/T2 sums, next a and e, and the next schedule word.
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
// Ports: kt/ch/maj/sum1/sum0/sigm1/sigm0/d/h round terms, words = 16-word window
//        (index 15 = W[t], index 6 = W[t+9]); o_a/o_d = new a/e, o_word = W[t+16].
module sha_adder
   import sha_round_ctrl_pkg::*;
(
   input  word_t  kt,
   input  word_t  ch,
   input  word_t  maj,
   input  word_t  sum1,
   input  word_t  sum0,
   input  word_t  sigm1,
   input  word_t  sigm0,
   input  word_t  d,
   input  word_t  h,
   input  block_t words,
   output word_t  o_a,
   output word_t  o_d,
   output word_t  o_word
);

   word_t wt;
   word_t w9;
   word_t t1;
   word_t t2;
   logic  unused_words;

   assign wt = words[`IDX32(15)];
   assign w9 = words[`IDX32(6)];
   // Only two window slots feed the adder; the rest are consumed by the
   // sigma functions upstream.
   assign unused_words = ^words;

`ifdef SHA_ADDER_CSA
   // 3:2 compression chain so only one carry-propagate add closes T1.
   function automatic csa_t csa(input word_t x, input word_t y, input word_t z);
      csa.s = x ^ y ^ z;
      csa.c = ((x & y) | (x & z) | (y & z)) << 1;
   endfunction

   csa_t l1;
   csa_t l2;
   csa_t l3;

   assign l1 = csa(h, sum1, ch);
   assign l2 = csa(l1.s, l1.c, kt);
   assign l3 = csa(l2.s, l2.c, wt);
   assign t1 = l3.s + l3.c;
`else
   assign t1 = h + sum1 + ch + kt + wt;
`endif

   assign t2     = sum0 + maj;
   assign o_a    = t1 + t2;
   assign o_d    = d + t1;
   assign o_word = sigm1 + w9 + sigm0 + wt;

endmodule

// File: rtl/sha_round_ctrl.sv
// SHA-256 compression sequencer: 64 rounds, one per clock, then the chaining add.
// Latency: 65 cycles from start-accept edge to o_done; one block per 66 cycles back to back.
// Backpressure: i_start ignored (not queued) while busy; accepted again in the o_done cycle.
// Ports: i_clk, i_rst (async, active-high); bus = slave side of sha_round_ctrl_if.
module sha_round_ctrl
   import sha_round_ctrl_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst,
   sha_round_ctrl_if.slave bus
);

   state_t     state;
   logic [5:0] t;
   logic       busy_q;
   logic       done_q;
   word_t      var_q  [8];   // a..h at indices 0..7
   word_t      hash_q [8];   // H0..H7
   word_t      w      [16];  // w[15] = W[t], w[0] = newest word
   word_t      blk_w  [16];

   word_t  rnd_kt;
   word_t  rnd_ch;
   word_t  rnd_maj;
   word_t  rnd_sum1;
   word_t  rnd_sum0;
   word_t  rnd_sigm1;
   word_t  rnd_sigm0;
   block_t words;
   hash_t  hash_flat;
   word_t  new_a;
   word_t  new_e;
   word_t  new_word;

   for (genvar k = 0; k < 16; k++) begin : g_unpack
      assign blk_w[k] = bus.i_block[`IDX32(k)];
   end

   always_comb begin
      rnd_kt    = k_of(t);
      rnd_ch    = f_ch(var_q[4], var_q[5], var_q[6]);
      rnd_maj   = f_maj(var_q[0], var_q[1], var_q[2]);
      rnd_sum1  = f_bsig1(var_q[4]);
      rnd_sum0  = f_bsig0(var_q[0]);
      rnd_sigm1 = f_ssig1(w[1]);
      rnd_sigm0 = f_ssig0(w[14]);
      words     = '0;
      for (int k = 0; k < 16; k++) begin
         words[k*32 +: 32] = w[k];
      end
      hash_flat = '0;
      for (int i = 0; i < 8; i++) begin
         hash_flat[(7-i)*32 +: 32] = hash_q[i];
      end
   end

   sha_adder u_adder (
      .kt     (rnd_kt),
      .ch     (rnd_ch),
      .maj    (rnd_maj),
      .sum1   (rnd_sum1),
      .sum0   (rnd_sum0),
      .sigm1  (rnd_sigm1),
      .sigm0  (rnd_sigm0),
      .d      (var_q[3]),
      .h      (var_q[7]),
      .words  (words),
      .o_a    (new_a),
      .o_d    (new_e),
      .o_word (new_word)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state  <= ST_IDLE;
         t      <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            var_q[i]  <= '0;
            hash_q[i] <= IV[i];
         end
         for (int k = 0; k < 16; k++) begin
            w[k] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.i_start) begin
                  state  <= ST_ROUND;
                  busy_q <= 1'b1;
                  t      <= '0;
                  for (int k = 0; k < 16; k++) begin
                     w[k] <= blk_w[k];
                  end
                  for (int i = 0; i < 8; i++) begin
                     var_q[i] <= bus.i_first ? IV[i] : hash_q[i];
                     if (bus.i_first) begin
                        hash_q[i] <= IV[i];
                     end
                  end
               end
            end
            ST_ROUND: begin
               var_q[0] <= new_a;
               var_q[1] <= var_q[0];
               var_q[2] <= var_q[1];
               var_q[3] <= var_q[2];
               var_q[4] <= new_e;
               var_q[5] <= var_q[4];
               var_q[6] <= var_q[5];
               var_q[7] <= var_q[6];
               // Words generated in the last 16 rounds fall off unused.
               w[0] <= new_word;
               for (int k = 1; k < 16; k++) begin
                  w[k] <= w[k-1];
               end
               t <= t + 6'd1;
               if (t == 6'(ROUNDS - 1)) begin
                  state <= ST_FINAL;
               end
            end
            ST_FINAL: begin
               for (int i = 0; i < 8; i++) begin
                  hash_q[i] <= hash_q[i] + var_q[i];
               end
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_busy = busy_q;
   assign bus.o_done = done_q;
   assign bus.o_hash = hash_flat;

endmodule
